serial_addsub_ctrl: RTL
=======================

// Module: serial_addsub_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer that time-shares a single 1-bit FULL_ADDER.
//  Latches two WIDTH-bit operands and feeds one bit pair per clock, LSB first,
//  through the adder. A carry flip-flop closes the loop between bits.
//  Collects the result and flags, then signals completion with a one-cycle DONE pulse.
//  Serves as the low-area ALU add/sub path, started by the control unit.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=2)
// PORTS
//  CLK     in   1      clock; all state changes on rising edge
//  RST     in   1      synchronous, active-high reset
//  START   in   1      request; sampled only when BUSY=0
//  SUB     in   1      0: R=A+B, 1: R=A-B; sampled with START
//  A       in   WIDTH  operand A; sampled with START
//  B       in   WIDTH  operand B; sampled with START
//  BUSY    out  1      1 while in RUN state
//  DONE    out  1      one-cycle pulse; R/CO/OV/ZERO valid from this cycle
//  R       out  WIDTH  result, held until the next DONE
//  CO      out  1      final carry out of bit WIDTH-1 (SUB: 1 = no borrow)
//  OV      out  1      signed overflow = carry into MSB XOR carry out of MSB
//  ZERO    out  1      1 when R == 0
// BEHAVIOUR
//  States: IDLE, RUN, FIN. Reset -> IDLE.
//  Reset values: BUSY=0, DONE=0, R=0, CO=0, OV=0, ZERO=1, bit counter=0, carry FF=0.
//  IDLE/FIN with START=1 at edge:
//   - a_sh <= A, b_sh <= B ^ {WIDTH{SUB}}, carry <= SUB, cnt <= 0
//   - go to RUN
//  IDLE/FIN with START=0: FIN -> IDLE; IDLE stays in IDLE.
//  RUN, each cycle:
//   - S,CO_fa = FULL_ADDER(a_sh[0], b_sh[0], carry)
//   - s_sh <= {S, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right 1; carry <= CO_fa; cnt++
//   - when cnt==WIDTH-2, also latch c_msb_in <= CO_fa (carry into MSB)
//   - when cnt==WIDTH-1 (MSB cycle):
//       R <= {S, s_sh[WIDTH-1:1]}; CO <= CO_fa; OV <= c_msb_in ^ CO_fa
//       ZERO <= (R_next == 0); go to FIN
//  FIN: DONE=1, BUSY=0 for exactly one cycle.
//  Latency: START accepted at edge k -> BUSY=1 for edges k+1..k+WIDTH;
//   DONE=1 in the cycle after edge k+WIDTH.
//  Back-to-back: START in the FIN cycle is accepted. DONE still pulses only once;
//   the next RUN begins immediately.
//  START/SUB/A/B are ignored while BUSY=1; the operation in flight is unaffected.
//  R, CO, OV, ZERO change only at the MSB-cycle edge (or reset); stable between operations.
//  Arithmetic is modulo 2^WIDTH. SUB uses the two's complement A + ~B + 1.
//  RST=1 mid-RUN aborts: next state IDLE, every output at its reset value, no DONE pulse.
//   RST has priority over START.
//  Adder datapath is strictly 1 bit wide: exactly one FULL_ADDER instance, no WIDTH-bit '+'.
// TESTING (bench WIDTH=8 unless noted)
//  1. RST, then A=8'h12, B=8'h34, SUB=0, START 1 cycle
//     -> BUSY high 8 cycles; DONE pulse; R=8'h46, CO=0, OV=0, ZERO=0.
//  2. A=8'hFF, B=8'h01, add -> R=8'h00, CO=1, OV=0, ZERO=1.
//     Then A=8'h7F, B=8'h01, add -> R=8'h80, OV=1, CO=0.
//  3. A=8'h05, B=8'h07, SUB=1 -> R=8'hFE, CO=0 (borrow).
//     Then A=8'h80, B=8'h01, SUB=1 -> R=8'h7F, OV=1, CO=1.
//  4. START held high continuously for 3 ops (A/B changed only in FIN cycles)
//     -> DONE every WIDTH+1 cycles; mid-RUN A/B changes do not alter results.
//  5. Assert RST at RUN cycle 4 of an op -> next cycle BUSY=0, R=0, ZERO=1; no DONE.
//     A fresh START after RST completes correctly.
//  6. WIDTH=32: random 1000 add/sub ops; R/CO/OV/ZERO checked against a behavioural model.

Source files
------------

// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - operand/result bundle for the bit-serial add/sub sequencer
// master drives the request side, slave (the sequencer) drives status and results.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic             co;
  logic             ov;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, r, co, ov, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, r, co, ov, zero
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer around one 1-bit full adder
// Operands shift out LSB first; a carry flop links consecutive bit cycles.
module serial_addsub_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_addsub_ctrl_if.slave  io_bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_s_sh;
  logic             r_carry;
  logic             r_c_msb_in;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_r;
  logic             r_co;
  logic             r_ov;
  logic             r_zero;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum;

  serial_addsub_full_adder u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_c  (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // New sum bit enters at the top; the low WIDTH-1 bits already collected sit below it.
  assign w_sum = {w_s, r_s_sh};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_s_sh     <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_r        <= '0;
      r_co       <= 1'b0;
      r_ov       <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            // Subtraction is A + ~B + 1: invert B up front and seed the carry with 1.
            r_a_sh  <= io_bus.a;
            r_b_sh  <= io_bus.b ^ {WIDTH{io_bus.sub}};
            r_carry <= io_bus.sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_s_sh  <= w_sum[WIDTH-1:1];
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == PENULT) begin
            r_c_msb_in <= w_co;
          end
          if (r_cnt == LAST) begin
            r_r     <= w_sum;
            r_co    <= w_co;
            r_ov    <= r_c_msb_in ^ w_co;
            r_zero  <= (w_sum == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.r    = r_r;
  assign io_bus.co   = r_co;
  assign io_bus.ov   = r_ov;
  assign io_bus.zero = r_zero;
endmodule
